// File: rtl/axi_stream_strip_header_if.sv
// ----------------------------------------------------------------------------
// axi_stream_strip_header_if
// Purpose : AXI-Stream style beat bundle shared by the payload input, the
//           payload output and the extracted-header output of
//           axi_stream_strip_header.
// Signals : valid  beat valid (driven by master)
//           data   DATA_WD bits, byte 0 in the MSB position
//           keep   DATA_WD/8 left-aligned byte enables
//           last   final beat of a packet
//           ready  beat accepted when valid && ready (driven by slave)
// ----------------------------------------------------------------------------
interface axi_stream_strip_header_if #(
    parameter int DATA_WD = 32
);
    logic                   valid;
    logic [DATA_WD-1:0]     data;
    logic [DATA_WD/8-1:0]   keep;
    logic                   last;
    logic                   ready;

    modport master (output valid, output data, output keep, output last, input  ready);
    modport slave  (input  valid, input  data, input  keep, input  last, output ready);
endinterface

// File: rtl/axi_stream_strip_header.sv
// ----------------------------------------------------------------------------
// axi_stream_strip_header
// Purpose : Strips an N-byte header (N = byte_strip_cnt+1, 1..DATA_BYTE_WD)
//           from the front of each AXI-Stream packet, presents the header on
//           a side channel and re-aligns the remaining payload to byte 0.
// Ports   : clk, rst        clock (rising edge), asynchronous active-high reset
//           s_axis          payload input  (valid/data/keep/last in, ready out)
//           m_axis          payload output (valid/data/keep/last out, ready in)
//           valid_strip     strip command valid, one per packet
//           byte_strip_cnt  header length minus one
//           ready_strip     command accepted when valid_strip && ready_strip
//           m_header        extracted header (keep left-aligned, last tied 0)
// ----------------------------------------------------------------------------
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_stream_strip_header_if.slave  s_axis,
    axi_stream_strip_header_if.master m_axis,
    input  logic                      valid_strip,
    input  logic [BYTE_CNT_WD-1:0]    byte_strip_cnt,
    output logic                      ready_strip,
    axi_stream_strip_header_if.master m_header
);
    // Byte counts range 0..DATA_BYTE_WD, so one extra bit over the command field.
    localparam int LEN_WD   = BYTE_CNT_WD + 1;
    localparam int SHIFT_WD = LEN_WD + 3;

    typedef logic [LEN_WD-1:0] len_t;
    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    // Left-aligned byte-enable vector with n leading ones.
    function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input len_t n);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[DATA_BYTE_WD-1-i] = (len_t'(i) < n);
        end
        return m;
    endfunction

    function automatic len_t keep_count(input logic [DATA_BYTE_WD-1:0] k);
        len_t c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (k[i]) c = c + len_t'(1);
        end
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    function automatic logic [SHIFT_WD-1:0] bits_of(input len_t n);
        return {n, 3'b000};
    endfunction

    state_t               state_q, state_d;
    len_t                 n_q, n_d;
    len_t                 tail_len_q, tail_len_d;
    logic [DATA_WD-1:0]   res_q, res_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;

    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    logic                 ready_in;
    logic                 in_fire;
    logic                 out_free;
    logic                 hdr_free;
    logic [DATA_WD-1:0]   din;
    len_t                 l_in;
    len_t                 r_len;
    logic [DATA_WD-1:0]   shifted_res;
    logic [DATA_WD-1:0]   body_word;

    always_comb begin
        // Bytes beyond keep_in are zeroed up front so every later shift/OR
        // leaves unused output bytes at zero without further masking.
        din         = s_axis.data & byte_mask(s_axis.keep);
        l_in        = keep_count(s_axis.keep);
        r_len       = len_t'(DATA_BYTE_WD) - n_q;
        out_free    = !out_valid_q || m_axis.ready;
        hdr_free    = !hdr_valid_q || m_header.ready;
        // A shift by the full word width (N = DATA_BYTE_WD) yields zero residual.
        shifted_res = din << bits_of(n_q);
        body_word   = res_q | (din >> bits_of(r_len));

        case (state_q)
            HEAD:    ready_in = hdr_free;
            BODY:    ready_in = out_free;
            default: ready_in = 1'b0;
        endcase
        ready_strip = (state_q == IDLE);
        in_fire     = s_axis.valid && ready_in;

        state_d     = state_q;
        n_d         = n_q;
        tail_len_d  = tail_len_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        hdr_valid_d = hdr_valid_q;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;

        if (out_valid_q && m_axis.ready) out_valid_d = 1'b0;
        if (hdr_valid_q && m_header.ready) hdr_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_strip) begin
                    n_d     = len_t'(byte_strip_cnt) + len_t'(1);
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (in_fire) begin
                    hdr_valid_d = 1'b1;
                    hdr_data_d  = din & byte_mask(keep_mask(n_q));
                    hdr_keep_d  = keep_mask((l_in < n_q) ? l_in : n_q);
                    res_d       = shifted_res;
                    if (!s_axis.last) begin
                        state_d = BODY;
                    end else if (l_in > n_q) begin
                        // Single-beat packet with payload: flush it from TAIL.
                        tail_len_d = l_in - n_q;
                        state_d    = TAIL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BODY: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = body_word;
                    res_d       = shifted_res;
                    if (s_axis.last && (l_in <= n_q)) begin
                        out_keep_d = keep_mask(r_len + l_in);
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        if (s_axis.last) begin
                            tail_len_d = l_in - n_q;
                            state_d    = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q;
                    out_keep_d  = keep_mask(tail_len_q);
                    out_last_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            tail_len_q  <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            tail_len_q  <= tail_len_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign s_axis.ready   = ready_in;
    assign m_axis.valid   = out_valid_q;
    assign m_axis.data    = out_data_q;
    assign m_axis.keep    = out_keep_q;
    assign m_axis.last    = out_last_q;
    assign m_header.valid = hdr_valid_q;
    assign m_header.data  = hdr_data_q;
    assign m_header.keep  = hdr_keep_q;
    assign m_header.last  = 1'b0;
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// ----------------------------------------------------------------------------
// tb_axi_stream_strip_header
// Bench for axi_stream_strip_header at DATA_WD=32: table vectors, a pending
// header back-pressure sequence, randomised packets against a byte-level
// model, and a reset in the middle of a packet.
// ----------------------------------------------------------------------------
module tb_axi_stream_strip_header;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int                   cnt;
        int                   nb;
        logic [3:0][DW-1:0]   d;
        logic [3:0][BW-1:0]   k;
        logic [DW-1:0]        hd;
        logic [BW-1:0]        hk;
        int                   no;
        logic [2:0][DW-1:0]   od;
        logic [2:0][BW-1:0]   ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_strip = 1'b0;
    logic [1:0] byte_strip_cnt = 2'd0;
    logic       ready_strip;

    axi_stream_strip_header_if #(.DATA_WD(DW)) in_if ();
    axi_stream_strip_header_if #(.DATA_WD(DW)) out_if ();
    axi_stream_strip_header_if #(.DATA_WD(DW)) hdr_if ();

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis         (in_if),
        .m_axis         (out_if),
        .valid_strip    (valid_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .ready_strip    (ready_strip),
        .m_header       (hdr_if)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_out_q[$];
    beat_t exp_hdr_q[$];
    bit    rnd_mode = 1'b0;
    bit    hdr_hold = 1'b0;
    vec_t  vecs[4];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no matching event within bound", name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte-level reference: header = first min(N,len) bytes, payload = the
    // rest packed MSB-first into full words with a partial final word.
    task automatic push_model(input int cnt, input logic [7:0] pkt[$]);
        int    n;
        int    len;
        int    h;
        int    p;
        beat_t b;
        n   = cnt + 1;
        len = pkt.size();
        h   = (len < n) ? len : n;
        b   = '0;
        for (int i = 0; i < h; i++) begin
            b.data[DW-1-8*i -: 8] = pkt[i];
            b.keep[BW-1-i] = 1'b1;
        end
        exp_hdr_q.push_back(b);
        p = n;
        while (p < len) begin
            b = '0;
            for (int j = 0; j < BW; j++) begin
                if (p < len) begin
                    b.data[DW-1-8*j -: 8] = pkt[p];
                    b.keep[BW-1-j] = 1'b1;
                    p++;
                end
            end
            b.last = (p >= len);
            exp_out_q.push_back(b);
        end
    endtask

    function automatic logic [DW-1:0] make_data(input logic [7:0] pkt[$], input int b);
        logic [DW-1:0] d;
        d = DW'($urandom);
        for (int j = 0; j < BW; j++) begin
            if (BW*b + j < pkt.size()) d[DW-1-8*j -: 8] = pkt[BW*b + j];
        end
        return d;
    endfunction

    function automatic logic [BW-1:0] make_keep(input int len, input int b);
        logic [BW-1:0] k;
        for (int j = 0; j < BW; j++) k[BW-1-j] = (BW*b + j < len);
        return k;
    endfunction

    task automatic send_cmd(input int cnt);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(cnt);
        while (!done) begin
            @(negedge clk);
            if (ready_strip) done = 1'b1;
            else begin
                t++;
                if (t > 3000) begin
                    fail_now("cmd_timeout");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
    endtask

    task automatic present_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.keep  = k;
        in_if.last  = l;
    endtask

    task automatic wait_accept();
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_if.ready) done = 1'b1;
            else begin
                t++;
                if (t > 3000) begin
                    fail_now("beat_timeout");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.keep  = '0;
        in_if.last  = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        present_beat(d, k, l);
        wait_accept();
    endtask

    function automatic int rnd_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
    endfunction

    task automatic run_packet(input int cnt, input int len, input bit stall);
        logic [7:0] pkt[$];
        int nb;
        pkt = {};
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        push_model(cnt, pkt);
        if (stall) idle(rnd_stall());
        send_cmd(cnt);
        nb = (len + BW - 1) / BW;
        for (int b = 0; b < nb; b++) begin
            if (stall) idle(rnd_stall());
            drive_beat(make_data(pkt, b), make_keep(len, b), b == nb - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_out_q.size() != 0 || exp_hdr_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_eq("drain_pending", 64'(exp_out_q.size() + exp_hdr_q.size()), 64'(0));
        idle(4);
    endtask

    // Downstream/header ready: stall bursts of 0-15 cycles in random mode.
    task automatic ready_gen();
        int so;
        int sh;
        so = 0;
        sh = 0;
        out_if.ready = 1'b1;
        hdr_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rnd_mode) out_if.ready = 1'b1;
            else if (so > 0) begin
                so--;
                out_if.ready = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                so = $urandom_range(0, 15);
                out_if.ready = 1'b0;
            end else out_if.ready = 1'b1;

            if (hdr_hold) hdr_if.ready = 1'b0;
            else if (!rnd_mode) hdr_if.ready = 1'b1;
            else if (sh > 0) begin
                sh--;
                hdr_if.ready = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sh = $urandom_range(0, 15);
                hdr_if.ready = 1'b0;
            end else hdr_if.ready = 1'b1;
        end
    endtask

    task automatic monitor();
        beat_t po, ph, e;
        logic  pvo, pro, pvh, prh;
        pvo = 1'b0; pro = 1'b0; pvh = 1'b0; prh = 1'b0;
        po = '0; ph = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pvo = 1'b0;
                pvh = 1'b0;
            end else begin
                if (pvo && !pro)
                    check_eq("out_stable", 64'({out_if.valid, out_if.data, out_if.keep, out_if.last}),
                             64'({1'b1, po}));
                if (pvh && !prh)
                    check_eq("hdr_stable", 64'({hdr_if.valid, hdr_if.data, hdr_if.keep}),
                             64'({1'b1, ph.data, ph.keep}));
                if (out_if.valid && out_if.ready) begin
                    if (exp_out_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected actual=%h required=none", {out_if.data, out_if.keep, out_if.last});
                    end else begin
                        e = exp_out_q.pop_front();
                        check_eq("out_beat", 64'({out_if.data, out_if.keep, out_if.last}), 64'(e));
                    end
                end
                if (hdr_if.valid && hdr_if.ready) begin
                    if (exp_hdr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL hdr_unexpected actual=%h required=none", {hdr_if.data, hdr_if.keep});
                    end else begin
                        e = exp_hdr_q.pop_front();
                        check_eq("hdr_beat", 64'({hdr_if.data, hdr_if.keep}), 64'({e.data, e.keep}));
                    end
                end
                pvo = out_if.valid; pro = out_if.ready;
                po  = '{data: out_if.data, keep: out_if.keep, last: out_if.last};
                pvh = hdr_if.valid; prh = hdr_if.ready;
                ph  = '{data: hdr_if.data, keep: hdr_if.keep, last: 1'b0};
            end
        end
    endtask

    initial begin
        logic [7:0] pkt[$];
        beat_t b;

        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.keep  = '0;
        in_if.last  = 1'b0;

        vecs[0].cnt = 1; vecs[0].nb = 3;
        vecs[0].d[0] = 32'hAABBCCDD; vecs[0].k[0] = 4'b1111;
        vecs[0].d[1] = 32'h11223344; vecs[0].k[1] = 4'b1111;
        vecs[0].d[2] = 32'h55667788; vecs[0].k[2] = 4'b1100;
        vecs[0].hd = 32'hAABB0000; vecs[0].hk = 4'b1100; vecs[0].no = 2;
        vecs[0].od[0] = 32'hCCDD1122; vecs[0].ok[0] = 4'b1111;
        vecs[0].od[1] = 32'h33445566; vecs[0].ok[1] = 4'b1111;

        vecs[1].cnt = 0; vecs[1].nb = 2;
        vecs[1].d[0] = 32'h01020304; vecs[1].k[0] = 4'b1111;
        vecs[1].d[1] = 32'h05060708; vecs[1].k[1] = 4'b1110;
        vecs[1].hd = 32'h01000000; vecs[1].hk = 4'b1000; vecs[1].no = 2;
        vecs[1].od[0] = 32'h02030405; vecs[1].ok[0] = 4'b1111;
        vecs[1].od[1] = 32'h06070000; vecs[1].ok[1] = 4'b1100;

        vecs[2].cnt = 3; vecs[2].nb = 3;
        vecs[2].d[0] = 32'h0A0B0C0D; vecs[2].k[0] = 4'b1111;
        vecs[2].d[1] = 32'h11111111; vecs[2].k[1] = 4'b1111;
        vecs[2].d[2] = 32'h22220000; vecs[2].k[2] = 4'b1100;
        vecs[2].hd = 32'h0A0B0C0D; vecs[2].hk = 4'b1111; vecs[2].no = 2;
        vecs[2].od[0] = 32'h11111111; vecs[2].ok[0] = 4'b1111;
        vecs[2].od[1] = 32'h22220000; vecs[2].ok[1] = 4'b1100;

        vecs[3].cnt = 1; vecs[3].nb = 1;
        vecs[3].d[0] = 32'hA1B2C3D4; vecs[3].k[0] = 4'b1110;
        vecs[3].hd = 32'hA1B20000; vecs[3].hk = 4'b1100; vecs[3].no = 1;
        vecs[3].od[0] = 32'hC3000000; vecs[3].ok[0] = 4'b1000;

        fork
            monitor();
            ready_gen();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid_out", 64'(out_if.valid), 64'(0));
        check_eq("rst_valid_header", 64'(hdr_if.valid), 64'(0));
        check_eq("rst_out_regs", 64'({out_if.data, out_if.keep, out_if.last}), 64'(0));
        check_eq("rst_hdr_regs", 64'({hdr_if.data, hdr_if.keep}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready_strip", 64'(ready_strip), 64'(1));
        check_eq("idle_ready_in", 64'(in_if.ready), 64'(0));
        @(posedge clk);
        #1;

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            b = '{data: vecs[v].hd, keep: vecs[v].hk, last: 1'b0};
            exp_hdr_q.push_back(b);
            for (int j = 0; j < vecs[v].no; j++) begin
                b = '{data: vecs[v].od[j], keep: vecs[v].ok[j], last: (j == vecs[v].no - 1)};
                exp_out_q.push_back(b);
            end
            send_cmd(vecs[v].cnt);
            for (int j = 0; j < vecs[v].nb; j++)
                drive_beat(vecs[v].d[j], vecs[v].k[j], j == vecs[v].nb - 1);
            wait_drain();
        end

        // Previous header pending: next packet's first beat must stall
        hdr_hold = 1'b1;
        idle(2);
        run_packet(1, 7, 1'b0);
        pkt = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        push_model(2, pkt);
        send_cmd(2);
        present_beat(32'h5A6B7C8D, 4'b1111, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check_eq("hold_ready_in", 64'(in_if.ready), 64'(0));
            check_eq("hold_valid_header", 64'(hdr_if.valid), 64'(1));
            check_eq("hold_ready_strip", 64'(ready_strip), 64'(0));
        end
        @(posedge clk);
        #1;
        hdr_hold = 1'b0;
        wait_accept();
        wait_drain();

        // Randomised packets with stalls on every handshake
        rnd_mode = 1'b1;
        for (int p = 0; p < 200; p++)
            run_packet($urandom_range(0, 3), $urandom_range(1, 14), 1'b1);
        wait_drain();
        rnd_mode = 1'b0;
        idle(20);

        // Reset in the middle of a packet body
        pkt = {};
        for (int i = 0; i < 12; i++) pkt.push_back(8'($urandom));
        push_model(1, pkt);
        send_cmd(1);
        drive_beat(make_data(pkt, 0), 4'b1111, 1'b0);
        drive_beat(make_data(pkt, 1), 4'b1111, 1'b0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_valid_out", 64'(out_if.valid), 64'(0));
        check_eq("midrst_valid_header", 64'(hdr_if.valid), 64'(0));
        check_eq("midrst_out_regs", 64'({out_if.data, out_if.keep, out_if.last}), 64'(0));
        exp_out_q.delete();
        exp_hdr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready_strip", 64'(ready_strip), 64'(1));
        @(posedge clk);
        #1;
        run_packet(2, 10, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
